// File: rtl/seg_disp_sched_pkg.sv
// Shared types and constants for the segment display scheduler.
// State encodings double as the grant vector.
package seg_disp_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_e;

    localparam logic [3:0] HEX_IDLE = 4'h0;
    localparam logic [3:0] DP_IDLE  = 4'b1111;

endpackage

// File: rtl/seg_disp_sched_dwell_timer.sv
// Saturating dwell counter measuring how long the current owner has held
// the display; done marks that the minimum hold time has elapsed.
module dwell_timer #(
    parameter int DWELL = 25000000,
    parameter int CW    = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Clear on ownership change, otherwise count up and hold at LAST.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && count_q != LAST) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == LAST);

endmodule

// File: rtl/seg_disp_sched.sv
// Two-requester arbiter for a shared 4-digit display with a minimum dwell
// per owner; the display registers always show the next owner's data.
import seg_disp_sched_pkg::*;

module seg_disp_sched #(
    parameter int DWELL = 25000000,
    parameter int CW    = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [3:0]  dp0,
    input  logic [3:0]  dp1,
    output logic [1:0]  gnt,
    output logic [3:0]  hex3,
    output logic [3:0]  hex2,
    output logic [3:0]  hex1,
    output logic [3:0]  hex0,
    output logic [3:0]  dp_out,
    output logic        busy
);

    state_e      state_q;
    state_e      state_d;
    logic        last_q;
    logic        last_d;
    logic [15:0] hex_q;
    logic [15:0] hex_d;
    logic [3:0]  dp_q;
    logic [3:0]  dp_d;
    logic        dwell_done;
    logic        dwell_clr;
    logic        dwell_en;

    // Ownership decision: ties go to the requester not served last, and an
    // owner is preempted only by a waiting requester once dwell has elapsed.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                unique case (req)
                    2'b01:   state_d = OWN0;
                    2'b10:   state_d = OWN1;
                    2'b11:   state_d = last_q ? OWN0 : OWN1;
                    default: state_d = IDLE;
                endcase
            end
            OWN0: begin
                if (!req[0]) begin
                    state_d = req[1] ? OWN1 : IDLE;
                end else if (req[1] && dwell_done) begin
                    state_d = OWN1;
                end
            end
            OWN1: begin
                if (!req[1]) begin
                    state_d = req[0] ? OWN0 : IDLE;
                end else if (req[0] && dwell_done) begin
                    state_d = OWN0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pointer and display data follow whoever owns the display next.
    always_comb begin
        last_d = last_q;
        hex_d  = {HEX_IDLE, HEX_IDLE, HEX_IDLE, HEX_IDLE};
        dp_d   = DP_IDLE;
        unique case (state_d)
            OWN0: begin
                last_d = 1'b0;
                hex_d  = data0;
                dp_d   = dp0;
            end
            OWN1: begin
                last_d = 1'b1;
                hex_d  = data1;
                dp_d   = dp1;
            end
            default: begin
                last_d = last_q;
            end
        endcase
    end

    // State, last-served pointer and display registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            hex_q   <= {HEX_IDLE, HEX_IDLE, HEX_IDLE, HEX_IDLE};
            dp_q    <= DP_IDLE;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hex_q   <= hex_d;
            dp_q    <= dp_d;
        end
    end

    assign dwell_clr = (state_d != state_q);
    assign dwell_en  = (state_q != IDLE);

    dwell_timer #(
        .DWELL (DWELL),
        .CW    (CW)
    ) u_dwell (
        .clk   (clk),
        .reset (reset),
        .clr   (dwell_clr),
        .en    (dwell_en),
        .done  (dwell_done)
    );

    assign gnt    = state_q;
    assign busy   = (state_q != IDLE);
    assign hex3   = hex_q[15:12];
    assign hex2   = hex_q[11:8];
    assign hex1   = hex_q[7:4];
    assign hex0   = hex_q[3:0];
    assign dp_out = dp_q;

endmodule
